seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - four-digit multiplexed 7-segment scan controller
// Frame-synchronous display update, per-slot ghosting gap, optional leading-zero blanking.
module seg7_scan_ctrl #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_GAP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] GAP     = DW'(BLANK_GAP);

    typedef enum logic [0:0] {
        ST_OFF  = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   pending_q, pending_d;
    logic          pend_q, pend_d;
    logic [15:0]   display_q, display_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          frame_done_q, frame_done_d;

    logic          scanning;
    logic          slot_end;
    logic          frame_end;
    logic          xfer;
    logic [3:0]    nibble;
    logic          lz_blank;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0:    hex_to_seg = 7'b1000000;
            4'h1:    hex_to_seg = 7'b1111001;
            4'h2:    hex_to_seg = 7'b0100100;
            4'h3:    hex_to_seg = 7'b0110000;
            4'h4:    hex_to_seg = 7'b0011001;
            4'h5:    hex_to_seg = 7'b0010010;
            4'h6:    hex_to_seg = 7'b0000010;
            4'h7:    hex_to_seg = 7'b1111000;
            4'h8:    hex_to_seg = 7'b0000000;
            4'h9:    hex_to_seg = 7'b0010000;
            4'hA:    hex_to_seg = 7'b0001000;
            4'hB:    hex_to_seg = 7'b0000011;
            4'hC:    hex_to_seg = 7'b1000110;
            4'hD:    hex_to_seg = 7'b0100001;
            4'hE:    hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        idx_d        = idx_q;
        pending_d    = pending_q;
        pend_d       = pend_q;
        display_d    = display_q;
        seg_d        = 7'b1111111;
        an_d         = 4'b1111;
        frame_done_d = 1'b0;
        xfer         = 1'b0;

        // en is gated in here so dropping it blanks the very next output cycle
        scanning  = (state_q == ST_SCAN) && en;
        slot_end  = (div_q == DIV_MAX);
        frame_end = scanning && slot_end && (idx_q == 2'd3);
        nibble    = display_q[{idx_q, 2'b00} +: 4];
        lz_blank  = blank_lz && (idx_q != 2'd0) && ((display_q >> {idx_q, 2'b00}) == 16'h0000);

        case (state_q)
            ST_OFF: begin
                if (en) begin
                    state_d = ST_SCAN;
                    div_d   = '0;
                    idx_d   = 2'd0;
                    xfer    = pend_q;
                end
            end
            default: begin
                if (!en) begin
                    state_d = ST_OFF;
                    div_d   = '0;
                    idx_d   = 2'd0;
                end else if (slot_end) begin
                    div_d = '0;
                    idx_d = idx_q + 2'd1;
                    xfer  = frame_end && pend_q;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
        endcase

        if (xfer) begin
            display_d = pending_q;
            pend_d    = 1'b0;
        end
        // A coincident load wins the pending slot after the old value has moved on
        if (load) begin
            pending_d = value;
            pend_d    = 1'b1;
        end

        frame_done_d = frame_end;

        if (scanning && (div_q >= GAP)) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = lz_blank ? 7'b1111111 : hex_to_seg(nibble);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_OFF;
            div_q        <= '0;
            idx_q        <= 2'd0;
            pending_q    <= 16'h0000;
            pend_q       <= 1'b0;
            display_q    <= 16'h0000;
            seg_q        <= 7'b1111111;
            an_q         <= 4'b1111;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            pend_q       <= pend_d;
            display_q    <= display_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    seg7_scan_ctrl #(
        .CLK_DIV  (4),
        .BLANK_GAP(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .value     (value),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .an        (an),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0:    enc = 7'b1000000;
            4'h1:    enc = 7'b1111001;
            4'h2:    enc = 7'b0100100;
            4'h3:    enc = 7'b0110000;
            4'h4:    enc = 7'b0011001;
            4'h5:    enc = 7'b0010010;
            4'h6:    enc = 7'b0000010;
            4'h7:    enc = 7'b1111000;
            4'h8:    enc = 7'b0000000;
            4'h9:    enc = 7'b0010000;
            4'hA:    enc = 7'b0001000;
            4'hB:    enc = 7'b0000011;
            4'hC:    enc = 7'b1000110;
            4'hD:    enc = 7'b0100001;
            4'hE:    enc = 7'b0000110;
            default: enc = 7'b0001110;
        endcase
    endfunction

    task automatic chk_blank(input string tag);
        chk({tag, "_an"}, {12'h0, an}, 16'h000f);
        chk({tag, "_seg"}, {9'h0, seg}, 16'h007f);
        chk({tag, "_fd"}, {15'h0, frame_done}, 16'h0000);
    endtask

    // Walks one 16-cycle frame starting at the gap cycle of digit 0;
    // optionally strobes load after step s1 and/or s2.
    task automatic frame(input string name, input logic [15:0] disp, input logic lz,
                         input int s1, input logic [15:0] v1,
                         input int s2, input logic [15:0] v2);
        for (int s = 0; s < 16; s++) begin
            int         slot;
            int         d;
            logic [3:0] ea;
            logic [6:0] es;
            logic [3:0] nib;
            logic [15:0] upper;
            slot  = s / 4;
            d     = s % 4;
            nib   = disp[4*slot +: 4];
            upper = disp >> (4 * slot);
            @(negedge clk);
            if (d == 0) begin
                ea = 4'b1111;
                es = 7'b1111111;
            end else begin
                ea = ~(4'b0001 << slot);
                es = (lz && slot != 0 && upper == 16'h0) ? 7'b1111111 : enc(nib);
            end
            chk($sformatf("%s_an%0d", name, s), {12'h0, an}, {12'h0, ea});
            chk($sformatf("%s_seg%0d", name, s), {9'h0, seg}, {9'h0, es});
            chk($sformatf("%s_fd%0d", name, s), {15'h0, frame_done}, (s == 15) ? 16'h1 : 16'h0);
            load = 1'b0;
            if (s == s1) begin
                load  = 1'b1;
                value = v1;
            end
            if (s == s2) begin
                load  = 1'b1;
                value = v2;
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        load     = 1'b0;
        value    = 16'h0000;
        blank_lz = 1'b0;

        repeat (2) @(negedge clk);
        chk_blank("reset");
        rst   = 1'b0;
        load  = 1'b1;
        value = 16'h1A3F;
        @(negedge clk);
        chk_blank("off_load");
        load = 1'b0;
        en   = 1'b1;
        @(negedge clk);
        chk_blank("entry1");

        frame("f1_1a3f", 16'h1A3F, 1'b0, 3, 16'h1234, -1, 16'h0);
        frame("f2_1234", 16'h1234, 1'b0, 6, 16'h0007, -1, 16'h0);
        frame("f3_0007", 16'h0007, 1'b0, 2, 16'h1111, 14, 16'h2222);
        frame("f4_1111", 16'h1111, 1'b0, -1, 16'h0, -1, 16'h0);
        frame("f5_2222", 16'h2222, 1'b0, 4, 16'h0070, -1, 16'h0);
        blank_lz = 1'b1;
        frame("f6_lz0070", 16'h0070, 1'b1, 4, 16'h0000, -1, 16'h0);
        frame("f7_lz0000", 16'h0000, 1'b1, -1, 16'h0, -1, 16'h0);
        blank_lz = 1'b0;

        @(negedge clk);
        chk("endrop_gap_an", {12'h0, an}, 16'h000f);
        @(negedge clk);
        chk("endrop_d0_an", {12'h0, an}, 16'h000e);
        chk("endrop_d0_seg", {9'h0, seg}, {9'h0, enc(4'h0)});
        en = 1'b0;
        @(negedge clk);
        chk_blank("endrop_off1");
        @(negedge clk);
        chk_blank("endrop_off2");
        en = 1'b1;
        @(negedge clk);
        chk_blank("entry2");
        frame("f8_0000", 16'h0000, 1'b0, 2, 16'h1234, -1, 16'h0);
        frame("f9_1234", 16'h1234, 1'b0, -1, 16'h0, -1, 16'h0);

        @(negedge clk);
        chk("prerst_gap_an", {12'h0, an}, 16'h000f);
        load  = 1'b1;
        value = 16'h5678;
        @(negedge clk);
        chk("prerst_d0_an", {12'h0, an}, 16'h000e);
        chk("prerst_d0_seg", {9'h0, seg}, {9'h0, enc(4'h4)});
        load = 1'b0;
        @(negedge clk);
        chk("prerst_d0b_an", {12'h0, an}, 16'h000e);
        rst = 1'b1;
        #1;
        chk_blank("rst_async");
        @(negedge clk);
        chk_blank("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        chk_blank("entry3");
        frame("f10_0000", 16'h0000, 1'b0, -1, 16'h0, -1, 16'h0);
        frame("f11_0000", 16'h0000, 1'b0, -1, 16'h0, -1, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
